// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and
// instruction memory.
//   master (fetch unit): drives imem_req_valid/imem_req_addr and
//                        samples imem_req_ready, imem_rsp_valid and imem_rsp_data
//   slave  (memory)    : the mirror image of master
// The memory returns exactly one response per accepted request, at least
// one cycle after acceptance.
interface if_fetch_unit_if #(
    parameter int CPU_BUS_SIZE = 32
);
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [CPU_BUS_SIZE-1:0] imem_req_addr;
    logic                    imem_rsp_valid;
    logic [CPU_BUS_SIZE-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage.
// It issues one instruction-memory read per PC, with at most one request
// outstanding, and captures the returned word into the IF/ID register.
// It handles load-use stalls with a 1-entry buffer. On a branch or jump
// redirect it discards wrong-path responses.
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   pc                current PC from the PC-select register
//   hazard_stall      hold IF/ID and block new fetches
//   flush             redirect taken this cycle
//   if_id_pc_write    PC register load enable
//   pc_plus_4_wire    pc + 4 (combinational)
//   imem              request/response channel (master side)
//   if_id_instr / if_id_pc_plus_4 / if_id_valid   IF/ID pipeline register
module if_fetch_unit #(
    parameter int                      CPU_BUS_SIZE = 32,
    parameter logic [CPU_BUS_SIZE-1:0] NOP_INSTR    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CPU_BUS_SIZE-1:0] pc,
    input  logic                    hazard_stall,
    input  logic                    flush,
    output logic                    if_id_pc_write,
    output logic [CPU_BUS_SIZE-1:0] pc_plus_4_wire,
    if_fetch_unit_if.master         imem,
    output logic [CPU_BUS_SIZE-1:0] if_id_instr,
    output logic [CPU_BUS_SIZE-1:0] if_id_pc_plus_4,
    output logic                    if_id_valid
);
    // REQ : may issue; WAIT: request in flight; HOLD: response parked by stall;
    // DROP: request in flight whose response belongs to the wrong path.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CPU_BUS_SIZE-1:0] r_req_pc4;
    logic [CPU_BUS_SIZE-1:0] r_buf_instr, r_buf_pc4;
    logic [CPU_BUS_SIZE-1:0] r_if_instr, r_if_pc4;
    logic                    r_if_valid;

    logic [CPU_BUS_SIZE-1:0] w_pc_plus_4;
    logic                    w_req_valid;
    logic                    w_accept;
    logic                    w_rsp_load;
    logic                    w_buf_load;
    logic                    w_buf_store;

    assign w_pc_plus_4    = pc + CPU_BUS_SIZE'(4);
    assign pc_plus_4_wire = w_pc_plus_4;

    assign imem.imem_req_addr  = pc;
    assign imem.imem_req_valid = w_req_valid;
    assign w_accept            = w_req_valid & imem.imem_req_ready;

    // A redirect always reloads the PC. Otherwise the PC advances only when a
    // fetch is accepted, so the address stays stable while ready is low.
    assign if_id_pc_write = rst_n & (flush | w_accept);

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_rsp_load  = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_store = 1'b0;
        case (r_state)
            S_REQ: begin
                // Gating by flush keeps a redirect from fetching the old PC.
                // A response arriving here is spurious (e.g. from before reset)
                // and is ignored.
                w_req_valid = rst_n & ~flush & ~hazard_stall;
                if (w_req_valid && imem.imem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (flush) begin
                        w_state_nxt = S_REQ;
                    end else if (hazard_stall) begin
                        w_buf_store = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_rsp_load  = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_state_nxt = S_REQ;
                end else if (!hazard_stall) begin
                    w_buf_load  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (imem.imem_rsp_valid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_req_pc4   <= '0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc4   <= '0;
            r_if_instr  <= NOP_INSTR;
            r_if_pc4    <= '0;
            r_if_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_req_pc4 <= w_pc_plus_4;
            if (w_buf_store) begin
                r_buf_instr <= imem.imem_rsp_data;
                r_buf_pc4   <= r_req_pc4;
            end
            // IF/ID priority: flush > stall > load > bubble.
            if (flush) begin
                r_if_instr <= NOP_INSTR;
                r_if_pc4   <= '0;
                r_if_valid <= 1'b0;
            end else if (hazard_stall) begin
                r_if_instr <= r_if_instr;
                r_if_pc4   <= r_if_pc4;
                r_if_valid <= r_if_valid;
            end else if (w_rsp_load) begin
                r_if_instr <= imem.imem_rsp_data;
                r_if_pc4   <= r_req_pc4;
                r_if_valid <= 1'b1;
            end else if (w_buf_load) begin
                r_if_instr <= r_buf_instr;
                r_if_pc4   <= r_buf_pc4;
                r_if_valid <= 1'b1;
            end else begin
                r_if_instr <= NOP_INSTR;
                r_if_pc4   <= '0;
                r_if_valid <= 1'b0;
            end
        end
    end

    assign if_id_instr     = r_if_instr;
    assign if_id_pc_plus_4 = r_if_pc4;
    assign if_id_valid     = r_if_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        hazard_stall = 1'b0;
    logic        flush = 1'b0;
    logic        if_id_pc_write;
    logic [31:0] pc_plus_4_wire;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus_4;
    logic        if_id_valid;

    if_fetch_unit_if #(.CPU_BUS_SIZE(W)) imem ();

    if_fetch_unit #(.CPU_BUS_SIZE(W), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .hazard_stall    (hazard_stall),
        .flush           (flush),
        .if_id_pc_write  (if_id_pc_write),
        .pc_plus_4_wire  (pc_plus_4_wire),
        .imem            (imem),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_valid     (if_id_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        e_rv;
        logic        e_pcw;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_v;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [31:0] p, input logic st, input logic fl,
                                input logic rdy, input logic rv, input logic [31:0] d,
                                input logic erv, input logic epcw, input logic [31:0] ei,
                                input logic [31:0] ep4, input logic ev);
        vec_t v;
        v.rst_n = r; v.pc = p; v.stall = st; v.flush = fl; v.ready = rdy; v.rsp_v = rv; v.rsp_d = d;
        v.e_rv = erv; v.e_pcw = epcw; v.e_instr = ei; v.e_pc4 = ep4; v.e_v = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n               = v.rst_n;
        pc                  = v.pc;
        hazard_stall        = v.stall;
        flush               = v.flush;
        imem.imem_req_ready = v.ready;
        imem.imem_rsp_valid = v.rsp_v;
        imem.imem_rsp_data  = v.rsp_d;
    endtask

    // Samples at the falling edge. Returns just after the next rising edge.
    task automatic check_cycle(input string tag, input logic e_rv, input logic e_pcw,
                               input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_v);
        logic [31:0] e_p4;
        e_p4 = pc + 32'd4;
        @(negedge clk);
        chk({tag, " req_valid"}, {31'b0, imem.imem_req_valid}, {31'b0, e_rv});
        chk({tag, " req_addr"},  imem.imem_req_addr, pc);
        chk({tag, " pc_write"},  {31'b0, if_id_pc_write}, {31'b0, e_pcw});
        chk({tag, " pc_plus_4"}, pc_plus_4_wire, e_p4);
        chk({tag, " if_id_instr"}, if_id_instr, e_instr);
        chk({tag, " if_id_pc4"}, if_id_pc_plus_4, e_pc4);
        chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_v});
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference state for the random phase
    logic [31:0] fly_pc4[$];
    bit          fly_drop[$];
    logic [63:0] held[$];
    logic [31:0] m_instr, m_pc4, rpc, p4, nxt_pc;
    logic        m_v, e_rv, e_pcw, dlv, dd;
    logic [63:0] dv;
    int          mem_cnt;

    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;

        //        rst pc            st fl rdy rv data          erv pcw instr         pc4           v
        tbl.push_back(mk(0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h0,        0, 0, 1, 0, 32'h0,        1, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h4,        0, 0, 1, 1, 32'h20080005, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h4,        0, 0, 0, 0, 32'h0,        1, 0, 32'h20080005, 32'h4,  1));
        tbl.push_back(mk(1, 32'h10,       0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h10,       0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h10,       0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h10,       0, 0, 1, 0, 32'h0,        1, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h14,       0, 0, 0, 1, 32'h11111111, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h14,       0, 0, 1, 0, 32'h0,        1, 1, 32'h11111111, 32'h14, 1));
        tbl.push_back(mk(1, 32'h18,       1, 0, 0, 1, 32'h0000AAAA, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h18,       1, 0, 1, 0, 32'h0,        0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h18,       0, 0, 1, 0, 32'h0,        0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h18,       0, 0, 1, 0, 32'h0,        1, 1, 32'h0000AAAA, 32'h18, 1));
        tbl.push_back(mk(1, 32'h1C,       0, 1, 0, 0, 32'h0,        0, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h40,       0, 0, 1, 0, 32'h0,        0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h40,       0, 0, 1, 1, 32'hDEADBEEF, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h40,       0, 0, 1, 0, 32'h0,        1, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h44,       1, 0, 0, 1, 32'h12345678, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h44,       1, 1, 0, 0, 32'h0,        0, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 1, 0, 32'h0,        1, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h0,        0, 0, 0, 1, 32'hCAFEF00D, 0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0,  1));
        tbl.push_back(mk(1, 32'h0,        1, 1, 1, 0, 32'h0,        0, 1, 32'hCAFEF00D, 32'h0,  1));
        tbl.push_back(mk(1, 32'h80,       0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h80,       0, 0, 1, 0, 32'h0,        1, 1, NOP,          32'h0,  0));
        tbl.push_back(mk(0, 32'h80,       0, 0, 0, 0, 32'h0,        0, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h80,       0, 0, 0, 1, 32'h55555555, 1, 0, NOP,          32'h0,  0));
        tbl.push_back(mk(1, 32'h80,       0, 0, 0, 0, 32'h0,        1, 0, NOP,          32'h0,  0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            check_cycle($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_pcw,
                        tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_v);
        end

        // Hand sequence: a repeated flush while the wrong-path fetch is still
        // in flight stays in DROP. The late response is then thrown away.
        drive(mk(1, 32'h80,  0, 0, 1, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop accept", 1, 1, NOP, 32'h0, 0);
        drive(mk(1, 32'h84,  0, 1, 0, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop flush1", 0, 1, NOP, 32'h0, 0);
        drive(mk(1, 32'h200, 0, 1, 1, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop flush2", 0, 1, NOP, 32'h0, 0);
        drive(mk(1, 32'h300, 0, 0, 1, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop idle", 0, 0, NOP, 32'h0, 0);
        drive(mk(1, 32'h300, 0, 0, 1, 1, 32'h99999999, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop rsp", 0, 0, NOP, 32'h0, 0);
        drive(mk(1, 32'h300, 0, 0, 0, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("drop done", 1, 0, NOP, 32'h0, 0);

        // Hand sequence: 3-cycle memory latency. Accept in cycle T, response
        // in T+3, word visible in IF/ID in T+4.
        drive(mk(1, 32'h300, 0, 0, 1, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("lat accept", 1, 1, NOP, 32'h0, 0);
        drive(mk(1, 32'h304, 0, 0, 1, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("lat wait1", 0, 0, NOP, 32'h0, 0);
        check_cycle("lat wait2", 0, 0, NOP, 32'h0, 0);
        drive(mk(1, 32'h304, 0, 0, 1, 1, 32'h0BADF00D, 0, 0, NOP, 32'h0, 0));
        check_cycle("lat rsp", 0, 0, NOP, 32'h0, 0);
        drive(mk(1, 32'h304, 0, 0, 0, 0, 32'h0, 0, 0, NOP, 32'h0, 0));
        check_cycle("lat load", 1, 0, 32'h0BADF00D, 32'h304, 1);

        // Random phase. The bench plays both the PC register and the memory.
        rst_n = 1'b0; flush = 1'b0; hazard_stall = 1'b0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rpc = '0; mem_cnt = -1;
        m_instr = NOP; m_pc4 = '0; m_v = 1'b0;
        fly_pc4.delete(); fly_drop.delete(); held.delete();

        for (int c = 0; c < 3000; c++) begin
            hazard_stall        = ($urandom_range(0, 4) == 0);
            flush               = ($urandom_range(0, 9) == 0);
            imem.imem_req_ready = ($urandom_range(0, 3) != 0);
            imem.imem_rsp_data  = $urandom;
            imem.imem_rsp_valid = 1'b0;
            if (mem_cnt == 0) begin
                imem.imem_rsp_valid = 1'b1;
                mem_cnt = -1;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
            pc = rpc;

            e_rv  = (fly_pc4.size() == 0) && (held.size() == 0) && !flush && !hazard_stall;
            e_pcw = flush || (e_rv && imem.imem_req_ready);
            check_cycle($sformatf("rnd%0d", c), e_rv, e_pcw, m_instr, m_pc4, m_v);
            // The clock edge has now passed. Update the model from this cycle's inputs.

            dlv = 1'b0;
            dv  = '0;
            if (imem.imem_rsp_valid && fly_pc4.size() > 0) begin
                p4 = fly_pc4.pop_front();
                dd = fly_drop.pop_front();
                if (!dd && !flush) begin
                    if (hazard_stall) held.push_back({imem.imem_rsp_data, p4});
                    else begin
                        dlv = 1'b1;
                        dv  = {imem.imem_rsp_data, p4};
                    end
                end
            end else if (flush && fly_pc4.size() > 0) begin
                fly_drop[0] = 1'b1;
            end else if (held.size() > 0) begin
                if (flush) held.delete();
                else if (!hazard_stall) begin
                    dlv = 1'b1;
                    dv  = held.pop_front();
                end
            end

            if (flush) begin
                m_instr = NOP; m_pc4 = '0; m_v = 1'b0;
            end else if (!hazard_stall) begin
                if (dlv) begin
                    m_instr = dv[63:32]; m_pc4 = dv[31:0]; m_v = 1'b1;
                end else begin
                    m_instr = NOP; m_pc4 = '0; m_v = 1'b0;
                end
            end

            if (e_rv && imem.imem_req_ready) begin
                fly_pc4.push_back(rpc + 32'd4);
                fly_drop.push_back(1'b0);
                mem_cnt = $urandom_range(0, 2);
            end
            if (e_pcw) begin
                nxt_pc = $urandom;
                rpc = flush ? {nxt_pc[31:2], 2'b00} : rpc + 32'd4;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
